branch_target_buffer: RTL and testbench

- Branch prediction unit for the RV32 pipeline. It supplies a predicted next PC to the next-PC selection logic in IF.
- It receives branch resolution from EX and reports mispredictions back to that logic, which redirects fetch and flushes the pipeline.
- It has a direct-mapped, tagged target table with a 2-bit saturating counter per entry.
- Lookup is combinational from registered state. Update is synchronous on the EX resolution.

---
 rtl/branch_target_buffer_if.sv | 24 ++
 rtl/branch_target_buffer.sv | 84 ++++++++
 tb/tb_branch_target_buffer.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/branch_target_buffer_if.sv
// Fetch/execute side signals exchanged between the pipeline and the branch target buffer.
interface branch_target_buffer_if;
  logic [31:0] PCF;
  logic        PredTakenF;
  logic [31:0] PredTargetF;
  logic        BrInstE;
  logic        BranchE;
  logic [31:0] PCE;
  logic [31:0] BranchTarget;
  logic        PredTakenE;
  logic [31:0] PredTargetE;
  logic        MispredictE;
  logic [31:0] CorrectPCE;

  modport master (
    output PCF, BrInstE, BranchE, PCE, BranchTarget, PredTakenE, PredTargetE,
    input  PredTakenF, PredTargetF, MispredictE, CorrectPCE
  );

  modport slave (
    input  PCF, BrInstE, BranchE, PCE, BranchTarget, PredTakenE, PredTargetE,
    output PredTakenF, PredTargetF, MispredictE, CorrectPCE
  );
endinterface

// File: rtl/branch_target_buffer.sv
// Direct-mapped tagged branch target buffer with 2-bit saturating counters.
// Combinational lookup for IF, synchronous update and mispredict detection for EX.
module branch_target_buffer #(
  parameter int ENTRIES = 64,
  parameter int TAG_W   = 30 - $clog2(ENTRIES)
) (
  input  logic                    CPU_CLK,
  input  logic                    CPU_RST_N,
  branch_target_buffer_if.slave   bus
);
  localparam int IDX_W = $clog2(ENTRIES);

  logic [ENTRIES-1:0] valid;
  logic [1:0]         ctr    [ENTRIES];
  logic [TAG_W-1:0]   tag    [ENTRIES];
  logic [31:0]        target [ENTRIES];

  logic [IDX_W-1:0] idx_f;
  logic [TAG_W-1:0] tag_f;
  logic             hit_f;
  logic [IDX_W-1:0] idx_e;
  logic [TAG_W-1:0] tag_e;
  logic             hit_e;
  logic [31:0]      pc_plus4_e;

  assign idx_f = bus.PCF[IDX_W+1:2];
  assign tag_f = bus.PCF[31:IDX_W+2];
  assign idx_e = bus.PCE[IDX_W+1:2];
  assign tag_e = bus.PCE[31:IDX_W+2];

  // Lookup reads registered state only, so a same-cycle update is seen next cycle.
  assign hit_f           = valid[idx_f] && (tag[idx_f] == tag_f);
  assign bus.PredTakenF  = hit_f && ctr[idx_f][1];
  assign bus.PredTargetF = bus.PredTakenF ? target[idx_f] : 32'b0;

  assign hit_e      = valid[idx_e] && (tag[idx_e] == tag_e);
  assign pc_plus4_e = bus.PCE + 32'd4;

  always_comb begin
    bus.MispredictE = 1'b0;
    bus.CorrectPCE  = pc_plus4_e;
    if (bus.BrInstE) begin
      if (bus.BranchE) begin
        bus.MispredictE = !bus.PredTakenE || (bus.PredTargetE != bus.BranchTarget);
        bus.CorrectPCE  = bus.BranchTarget;
      end else begin
        bus.MispredictE = bus.PredTakenE;
      end
    end else begin
      // A taken prediction on a non-branch came from an aliased entry.
      bus.MispredictE = bus.PredTakenE;
    end
  end

  always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
    if (!CPU_RST_N) begin
      valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        ctr[i] <= 2'b01;
      end
    end else if (bus.BrInstE) begin
      if (hit_e) begin
        if (bus.BranchE) begin
          ctr[idx_e] <= (ctr[idx_e] == 2'd3) ? 2'd3 : ctr[idx_e] + 2'd1;
        end else begin
          ctr[idx_e] <= (ctr[idx_e] == 2'd0) ? 2'd0 : ctr[idx_e] - 2'd1;
        end
      end else if (bus.BranchE) begin
        valid[idx_e] <= 1'b1;
        ctr[idx_e]   <= 2'b10;
      end
    end else if (bus.PredTakenE) begin
      valid[idx_e] <= 1'b0;
    end
  end

  // Tag and target need no reset; gating on reset keeps a write from landing mid-reset.
  always_ff @(posedge CPU_CLK) begin
    if (CPU_RST_N && bus.BrInstE && bus.BranchE) begin
      tag[idx_e]    <= tag_e;
      target[idx_e] <= bus.BranchTarget;
    end
  end
endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench for branch_target_buffer: directed scenarios then randomized
// traffic, all compared against a table-level behavioural model.
module tb_branch_target_buffer;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  branch_target_buffer_if bus_if ();

  branch_target_buffer #(.ENTRIES(64)) dut (
    .CPU_CLK   (clk),
    .CPU_RST_N (rst_n),
    .bus       (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state, indexed by (pc / 4) mod 64 with tag pc / 256.
  bit          m_valid  [64];
  int unsigned m_tag    [64];
  int unsigned m_target [64];
  int          m_ctr    [64];

  function automatic int unsigned idx_of(input int unsigned pc);
    return (pc / 4) % 64;
  endfunction

  function automatic int unsigned tag_of(input int unsigned pc);
    return pc / 256;
  endfunction

  function automatic bit model_hit(input int unsigned pc);
    return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
  endfunction

  function automatic bit model_taken(input int unsigned pc);
    return model_hit(pc) && (m_ctr[idx_of(pc)] >= 2);
  endfunction

  function automatic int unsigned model_target(input int unsigned pc);
    return model_taken(pc) ? m_target[idx_of(pc)] : 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 1;
    end
  endtask

  task automatic model_update(input bit br, input bit bt, input int unsigned pce,
                              input int unsigned target, input bit pte);
    int unsigned i;
    i = idx_of(pce);
    if (br) begin
      if (model_hit(pce)) begin
        if (bt) begin
          m_ctr[i]    = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
          m_target[i] = target;
        end else begin
          m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
        end
      end else if (bt) begin
        m_valid[i]  = 1'b1;
        m_tag[i]    = tag_of(pce);
        m_target[i] = target;
        m_ctr[i]    = 2;
      end
    end else if (pte) begin
      m_valid[i] = 1'b0;
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", name, observed, expected);
    end
  endtask

  // One pipeline cycle: drive after the falling edge, check outputs against the
  // pre-update model, then advance the model for the coming rising edge.
  task automatic applyStimulus(input int unsigned pcf, input bit br, input bit bt,
                               input int unsigned pce, input int unsigned target,
                               input bit pte, input int unsigned ptge);
    bit          exp_mis;
    int unsigned exp_pc;
    @(negedge clk);
    bus_if.PCF          = pcf;
    bus_if.BrInstE      = br;
    bus_if.BranchE      = bt;
    bus_if.PCE          = pce;
    bus_if.BranchTarget = target;
    bus_if.PredTakenE   = pte;
    bus_if.PredTargetE  = ptge;
    #1;
    if (br && bt) begin
      exp_mis = !pte || (ptge != target);
      exp_pc  = target;
    end else begin
      exp_mis = pte;
      exp_pc  = pce + 4;
    end
    checkOutput("PredTakenF", {31'b0, bus_if.PredTakenF}, {31'b0, model_taken(pcf)});
    checkOutput("PredTargetF", bus_if.PredTargetF, model_target(pcf));
    checkOutput("MispredictE", {31'b0, bus_if.MispredictE}, {31'b0, exp_mis});
    checkOutput("CorrectPCE", bus_if.CorrectPCE, exp_pc);
    model_update(br, bt, pce, target, pte);
  endtask

  task automatic idleLookup(input int unsigned pcf);
    applyStimulus(pcf, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic resolveWithTable(input int unsigned pc, input bit bt, input int unsigned target);
    applyStimulus(pc, 1'b1, bt, pc, target, model_taken(pc), model_target(pc));
  endtask

  initial begin
    int unsigned pc;
    int unsigned tgt;
    bit          br;
    bit          bt;
    bit          pte;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus_if.PCF          = 32'h0;
    bus_if.BrInstE      = 1'b0;
    bus_if.BranchE      = 1'b0;
    bus_if.PCE          = 32'h0;
    bus_if.BranchTarget = 32'h0;
    bus_if.PredTakenE   = 1'b0;
    bus_if.PredTargetE  = 32'h0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] reset state and invalid-table sweep");
    idleLookup(32'h100);
    checkOutput("reset_PredTakenF", {31'b0, bus_if.PredTakenF}, 32'h0);
    checkOutput("reset_PredTargetF", bus_if.PredTargetF, 32'h0);
    for (int i = 0; i < 64; i++) begin
      idleLookup(i * 4);
    end

    $display("[TB] allocate taken branch with same-cycle lookup");
    applyStimulus(32'h100, 1'b1, 1'b1, 32'h100, 32'h80, 1'b0, 32'h0);
    checkOutput("alloc_MispredictE", {31'b0, bus_if.MispredictE}, 32'h1);
    checkOutput("alloc_CorrectPCE", bus_if.CorrectPCE, 32'h80);
    checkOutput("hazard_PredTakenF", {31'b0, bus_if.PredTakenF}, 32'h0);
    idleLookup(32'h100);
    checkOutput("installed_PredTakenF", {31'b0, bus_if.PredTakenF}, 32'h1);
    checkOutput("installed_PredTargetF", bus_if.PredTargetF, 32'h80);

    $display("[TB] counter decrement and saturation");
    resolveWithTable(32'h100, 1'b0, 32'h80);
    checkOutput("nt1_MispredictE", {31'b0, bus_if.MispredictE}, 32'h1);
    checkOutput("nt1_CorrectPCE", bus_if.CorrectPCE, 32'h104);
    idleLookup(32'h100);
    checkOutput("ctr1_PredTakenF", {31'b0, bus_if.PredTakenF}, 32'h0);
    resolveWithTable(32'h100, 1'b0, 32'h80);
    checkOutput("nt2_MispredictE", {31'b0, bus_if.MispredictE}, 32'h0);
    resolveWithTable(32'h100, 1'b0, 32'h80);
    repeat (4) resolveWithTable(32'h100, 1'b1, 32'h80);
    resolveWithTable(32'h100, 1'b0, 32'h80);
    idleLookup(32'h100);
    checkOutput("sat_PredTakenF", {31'b0, bus_if.PredTakenF}, 32'h1);
    resolveWithTable(32'h100, 1'b0, 32'h80);
    idleLookup(32'h100);
    checkOutput("desat_PredTakenF", {31'b0, bus_if.PredTakenF}, 32'h0);

    $display("[TB] aliasing overwrite");
    resolveWithTable(32'h100, 1'b1, 32'h80);
    resolveWithTable(32'h200, 1'b1, 32'h400);
    idleLookup(32'h100);
    checkOutput("alias_old_PredTakenF", {31'b0, bus_if.PredTakenF}, 32'h0);
    idleLookup(32'h200);
    checkOutput("alias_new_PredTargetF", bus_if.PredTargetF, 32'h400);

    $display("[TB] target change and stale alias clear");
    resolveWithTable(32'h100, 1'b1, 32'h80);
    applyStimulus(32'h0, 1'b1, 1'b1, 32'h100, 32'h90, 1'b1, 32'h80);
    checkOutput("retarget_MispredictE", {31'b0, bus_if.MispredictE}, 32'h1);
    checkOutput("retarget_CorrectPCE", bus_if.CorrectPCE, 32'h90);
    idleLookup(32'h100);
    checkOutput("retarget_PredTargetF", bus_if.PredTargetF, 32'h90);
    applyStimulus(32'h0, 1'b0, 1'b0, 32'h100, 32'h0, 1'b1, 32'h90);
    checkOutput("stale_CorrectPCE", bus_if.CorrectPCE, 32'h104);
    idleLookup(32'h100);
    checkOutput("stale_PredTakenF", {31'b0, bus_if.PredTakenF}, 32'h0);
    applyStimulus(32'h0, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0, 1'b0, 32'h0);
    checkOutput("wrap_CorrectPCE", bus_if.CorrectPCE, 32'h0);

    $display("[TB] reset during pending update");
    resolveWithTable(32'h300, 1'b1, 32'h500);
    @(negedge clk);
    bus_if.PCF          = 32'h300;
    bus_if.BrInstE      = 1'b1;
    bus_if.BranchE      = 1'b1;
    bus_if.PCE          = 32'h100;
    bus_if.BranchTarget = 32'h700;
    bus_if.PredTakenE   = 1'b0;
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    checkOutput("inreset_PredTakenF", {31'b0, bus_if.PredTakenF}, 32'h0);
    @(negedge clk);
    bus_if.BrInstE = 1'b0;
    rst_n          = 1'b1;
    idleLookup(32'h300);
    checkOutput("postreset_PredTakenF", {31'b0, bus_if.PredTakenF}, 32'h0);
    idleLookup(32'h100);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 400; n++) begin
      pc  = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2);
      tgt = $urandom_range(0, 15) << 4;
      br  = ($urandom_range(0, 9) != 0);
      bt  = $urandom_range(0, 1);
      pte = br ? model_taken(pc) : ($urandom_range(0, 3) == 0);
      applyStimulus(($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2),
                    br, bt, pc, tgt, pte, model_taken(pc) ? model_target(pc) : tgt);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
